// File: rtl/iq_chip_sequencer.sv
// rtl/iq_chip_sequencer.sv - I/Q chip pair sequencer driving the 1:2 chip demux
// Optional symbol alignment check enabled by defining IQ_ALIGN_CHK_EN.
module iq_chip_sequencer #(
  parameter int CHIPS_PER_SYM = 32,
  parameter int CNT_W         = 4
) (
  input  logic             inClk,
  input  logic             inRst,
  input  logic             inChip,
  input  logic             inChipValid,
  input  logic             inChipFirst,
  output logic             outChipReady,
  output logic             outDemuxData,
  output logic             outDemuxSel,
  input  logic [1:0]       inDemuxData,
  output logic             outI,
  output logic             outQ,
  output logic             outPairValid,
  input  logic             inPairReady,
  output logic             outSymLast,
  output logic [CNT_W-1:0] outPairIdx
`ifdef IQ_ALIGN_CHK_EN
  ,
  output logic             outAlignErr
`endif
);

  localparam int PAIRS = CHIPS_PER_SYM / 2;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAIRS - 1);

  typedef enum logic [1:0] {
    GET_I   = 2'd0,
    GET_Q   = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t           state, nextState;
  logic             iReg, iNext;
  logic             qReg, qNext;
  logic [CNT_W-1:0] pairCnt, cntNext;
  logic             chipAccept;

`ifdef IQ_ALIGN_CHK_EN
  logic alignErr, errNext;
  logic selBit;
`else
  logic unusedChipFirst;
  assign unusedChipFirst = inChipFirst;
`endif

  always_ff @(posedge inClk) begin
    if (inRst) begin
      state   <= GET_I;
      iReg    <= 1'b0;
      qReg    <= 1'b0;
      pairCnt <= '0;
`ifdef IQ_ALIGN_CHK_EN
      alignErr <= 1'b0;
`endif
    end else begin
      state   <= nextState;
      iReg    <= iNext;
      qReg    <= qNext;
      pairCnt <= cntNext;
`ifdef IQ_ALIGN_CHK_EN
      alignErr <= errNext;
`endif
    end
  end

  always_comb begin
    nextState  = state;
    iNext      = iReg;
    qNext      = qReg;
    cntNext    = pairCnt;
    chipAccept = inChipValid && (state != PRESENT);
`ifdef IQ_ALIGN_CHK_EN
    errNext = alignErr;
    // The chip only lands on the currently selected demux leg.
    selBit  = (state == GET_I) ? inDemuxData[0] : inDemuxData[1];
`endif
    case (state)
      GET_I: begin
        if (chipAccept) begin
          iNext     = inDemuxData[0];
          nextState = GET_Q;
        end
      end
      GET_Q: begin
        if (chipAccept) begin
          qNext     = inDemuxData[1];
          nextState = PRESENT;
        end
      end
      PRESENT: begin
        if (inPairReady) begin
          nextState = GET_I;
          cntNext   = (pairCnt == LAST_IDX) ? '0 : pairCnt + CNT_W'(1);
        end
      end
      default: nextState = GET_I;
    endcase
`ifdef IQ_ALIGN_CHK_EN
    // A symbol-first chip resynchronises to the start of pair 0.
    if (chipAccept && inChipFirst) begin
      if ((state != GET_I) || (pairCnt != '0)) errNext = 1'b1;
      iNext     = selBit;
      nextState = GET_Q;
      cntNext   = '0;
    end
`endif
  end

  assign outDemuxData = inChip;
  assign outChipReady = (state != PRESENT);
  assign outDemuxSel  = (state != GET_I);
  assign outPairValid = (state == PRESENT);
  assign outSymLast   = (state == PRESENT) && (pairCnt == LAST_IDX);
  assign outPairIdx   = pairCnt;
  assign outI         = iReg;
  assign outQ         = qReg;
`ifdef IQ_ALIGN_CHK_EN
  assign outAlignErr  = alignErr;
`endif

endmodule

// File: doc/iq_chip_sequencer.md
# iq_chip_sequencer

Sequences the 1:2 bit demultiplexer that splits the serial spread-chip stream into I and Q chip pairs for the O-QPSK modulator. It accepts chips one at a time over a valid/ready handshake and drives the demux select: even chips go to I, odd chips go to Q. It captures both demux outputs into a pair register and presents each completed I/Q pair downstream over a second valid/ready handshake. It also tracks the pair position inside each symbol and flags the last pair.

## Interface
- `CHIPS_PER_SYM`, default 32: chips per symbol. Must be even and ≥ 2. Pairs per symbol is `CHIPS_PER_SYM/2`.
- `CNT_W`, default 4: pair counter width. Must satisfy `2**CNT_W ≥ CHIPS_PER_SYM/2`.

Clock and reset: one clock; reset is synchronous and active-high.
- `inClk` in 1: clock. All logic is on the rising edge.
- `inRst` in 1: synchronous, active-high reset.
- `inChip` in 1: serial chip value.
- `inChipValid` in 1: `inChip` is valid.
- `inChipFirst` in 1: the chip is the first chip of a symbol. Used only with `IQ_ALIGN_CHK_EN`.
- `outChipReady` out 1: the block accepts a chip this cycle.
- `outDemuxData` out 1: data to the demux input. Equal to `inChip`, combinational.
- `outDemuxSel` out 1: demux select. 0 routes the chip to I (bit 0); 1 routes it to Q (bit 1).
- `inDemuxData` in 2: demux outputs. Only the selected bit is sampled; the other bit may be `z`.
- `outI`, `outQ` out 1 each: captured pair.
- `outPairValid` out 1: the pair is valid.
- `inPairReady` in 1: the downstream consumer takes the pair.
- `outSymLast` out 1: the presented pair is the last pair of its symbol.
- `outPairIdx` out `CNT_W`: index of the presented pair within its symbol.
- `outAlignErr` out 1: sticky alignment error. Present only with `IQ_ALIGN_CHK_EN`.

## Operation
- A chip is accepted when `inChipValid && outChipReady` in the same cycle.
- A pair is taken when `outPairValid && inPairReady` in the same cycle.
- FSM states are `GET_I`, `GET_Q` and `PRESENT`. The reset state is `GET_I`.
- `GET_I`:
  - `outChipReady=1`, `outDemuxSel=0`.
  - On accept: `outI <= inDemuxData[0]`, then go to `GET_Q`.
- `GET_Q`:
  - `outChipReady=1`, `outDemuxSel=1`.
  - On accept: `outQ <= inDemuxData[1]`, then go to `PRESENT`.
- `PRESENT`:
  - `outChipReady=0`, `outPairValid=1`.
  - `outI`, `outQ`, `outPairIdx` and `outSymLast` are held stable until the pair is taken.
  - On take: go to `GET_I`. The pair counter increments, wrapping from `CHIPS_PER_SYM/2-1` to 0.
- `outSymLast` is 1 exactly when `outPairValid=1` and the pair counter equals `CHIPS_PER_SYM/2-1`.
- `outPairIdx` equals the pair counter.
- `outDemuxSel` in `PRESENT` holds 1, the last select value.
- Deasserting `inChipValid` in `GET_I` or `GET_Q` stalls the FSM. No state changes.
- Reset has priority over everything and may arrive mid-pair or mid-symbol:
  - A partially collected pair is discarded.
  - An unpresented pair is discarded.
  - The counter returns to 0.
- Reset value of every output:
  - `outChipReady=1`, `outDemuxSel=0`.
  - `outI=0`, `outQ=0`.
  - `outPairValid=0`, `outSymLast=0`, `outPairIdx=0`.
  - `outAlignErr=0`.

## Timing
- `outChipReady`, `outDemuxSel`, `outPairValid` and `outSymLast` are decoded from registered state only. They have no combinational path from the handshake inputs.
- Latency: `outPairValid` rises 1 cycle after the Q chip is accepted.
- Best-case throughput is 2 chips per 3 cycles. The sequence is: I accept, Q accept, pair take. There is no skid: no chip is accepted in `PRESENT`.
- Downstream backpressure (`inPairReady=0`) holds `PRESENT` indefinitely. Upstream sees `outChipReady=0` for that whole period.
- `inDemuxData` is sampled in the cycle the chip is accepted. The demux is combinational, so capture happens in the same cycle as acceptance.

## Configuration
- Macro: `IQ_ALIGN_CHK_EN`.
- With the macro defined, on a chip accept with `inChipFirst=1` the block checks its position:
  - If the state is not `GET_I` or the counter is not 0, `outAlignErr` is set to 1. It is sticky and cleared only by reset.
  - The block then resynchronises:
    - The chip is captured as I and the state goes to `GET_Q`.
    - The pending partial I is discarded.
    - The counter is forced to 0.
  - An accept with `inChipFirst=1` in `GET_I` with counter 0 is a normal accept. No error is flagged.
- With the macro undefined:
  - `inChipFirst` is ignored.
  - The `outAlignErr` port is absent.
  - Alignment is purely positional from reset.

## Test plan
- **Reset values:** assert `inRst` for 2 cycles. After release, expect `outChipReady=1`, `outDemuxSel=0`, `outPairValid=0`, `outPairIdx=0`.
- **Single pair:** drive chips 1 then 0 back-to-back with `inPairReady=1`.
  - `outDemuxSel` goes 0 then 1.
  - In the next cycle, `outI=1`, `outQ=0` and `outPairValid=1` for exactly 1 cycle.
- **Full symbol:** stream 32 chips alternating 1,1,0,0,… with `inPairReady=1`.
  - Expect 16 pairs with `outPairIdx` 0..15 and alternating I=Q=1 and I=Q=0.
  - `outSymLast=1` only on pair 15.
  - The 17th pair has `outPairIdx=0`.
- **Backpressure:** hold `inPairReady=0` for 5 cycles while in `PRESENT`.
  - The pair stays stable and `outChipReady=0` throughout.
  - Release: the pair is taken in 1 cycle and `outChipReady=1` in the next cycle.
- **Reset mid-pair:** accept an I chip of 1, then assert reset.
  - The state returns to `GET_I` and no pair is emitted.
  - The next chips 0,1 yield I=0, Q=1 with idx 0.
- **Alignment (`IQ_ALIGN_CHK_EN`):** after 5 chips, accept a chip with `inChipFirst=1`.
  - `outAlignErr=1` and stays 1.
  - The next pair has `outPairIdx=0`, with I equal to that chip.
